sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO: the next-generation buffer for the datapath. It generalises data width and depth, and adds:
- almost-full/almost-empty thresholds
- overflow/underflow error pulses
- a correctly sized occupancy count
- a selectable first-word-fall-through (FWFT) read mode

It sits between any producer/consumer pair in the same clock domain.

Parameters:
DATA_W, 32, data word width in bits
ADDR_W, 10, address width; DEPTH = 2**ADDR_W entries (default 1024)
AFULL_TH, 1020, almost_full asserted when count >= AFULL_TH (1..DEPTH)
AEMPTY_TH, 4, almost_empty asserted when count <= AEMPTY_TH (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
data_in  input  DATA_W  write data
wr  input  1  write request
rd  input  1  read request
data_out  output  DATA_W  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_TH
almost_empty  output  1  count <= AEMPTY_TH
fifo_cnt  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- Reset: rst sampled at posedge clk; it overrides wr/rd in that cycle.
  - wr_ptr, rd_ptr, fifo_cnt = 0; data_out = 0 (standard mode); overflow = underflow = 0.
  - Hence empty = 1, almost_empty = 1, full = 0, almost_full = 0 (AFULL_TH >= 1).
  - Storage contents are not reset. Reset mid-stream discards all entries; next read after reset is underflow.
- Storage: DEPTH x DATA_W array; all ADDR_W-bit pointers wrap modulo DEPTH naturally.
- Flags: full, empty, almost_full and almost_empty are combinational decodes of the registered fifo_cnt, so they update in the cycle after the causing edge.
- Accept rules, evaluated on the pre-edge state:
  - wr_ok = wr && (!full || rd)
  - rd_ok = rd && !empty
- Write: wr_ok stores data_in at wr_ptr, wr_ptr += 1.
- Read: rd_ok advances rd_ptr += 1.
- Count update:
  - wr_ok && !rd_ok: +1
  - rd_ok && !wr_ok: -1
  - both or neither: unchanged
  - Count never exceeds DEPTH and never goes below 0.
- Simultaneous wr&rd:
  - When full: both accepted, count stays DEPTH, no overflow.
  - When empty: write accepted, read rejected, underflow pulses, count becomes 1.
  - Otherwise: both accepted, count unchanged.
- Errors, registered one cycle after the offending edge, high for exactly 1 cycle per offending request:
  - overflow = wr && full && !rd
  - underflow = rd && empty
  - State is unchanged by a rejected request.
- FWFT = 0 (standard mode):
  - On rd_ok, data_out <= mem[rd_ptr] at the edge, so data appears 1 cycle after rd.
  - data_out holds its value otherwise, including on rejected reads.
- FWFT = 1:
  - data_out = mem[rd_ptr] combinationally; valid whenever !empty.
  - rd acknowledges/pops the shown word; the next word is visible in the following cycle.
  - When empty, data_out is don't-care; reset-value rules for data_out do not apply.
- Write-to-read latency:
  - Standard mode: empty deasserts 1 cycle after the write edge; earliest read data 1 cycle after that rd.
  - FWFT mode: word is visible on data_out 1 cycle after the write edge.
- Parameter legality, checked at elaboration: 1 <= AFULL_TH <= DEPTH, 0 <= AEMPTY_TH < DEPTH, FWFT in {0,1}.

Test Plan:
Bench configuration: DATA_W=8, ADDR_W=2 (DEPTH=4), AFULL_TH=3, AEMPTY_TH=1 unless stated.
1. Reset then idle -> empty=1, almost_empty=1, full=0, fifo_cnt=0, data_out=0x00, overflow=underflow=0.
2. Write 0x11,0x22,0x33,0x44 on consecutive cycles -> fifo_cnt 1,2,3,4; almost_full high at cnt=3; full=1 at cnt=4. Fifth write 0x55 -> overflow pulses 1 cycle, cnt stays 4. Reads then return 0x11,0x22,0x33,0x44 (0x55 absent); empty=1 after.
3. Pointer wrap: run 10 write/read pairs with values 0x00..0x09, interleaving singles and bursts of 3 -> in-order output, cnt tracks exactly, no error pulses.
4. Simultaneous events:
   - Full + wr&rd with 0xA5 -> cnt stays 4, no overflow; 0xA5 is read fifth.
   - Empty + wr&rd with 0x5A -> underflow pulse, cnt=1, next read returns 0x5A.
5. Reset mid-operation: with cnt=3, assert rst for 1 cycle alongside wr=1 -> cnt=0, empty=1, write dropped; next rd -> underflow pulse, data_out unchanged (0x00).
6. FWFT=1: write 0x77 -> data_out=0x77 the next cycle with no rd; write 0x88, assert rd -> data_out=0x88 the following cycle; rd again -> empty=1.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - producer/consumer bundle for the parametrised sync FIFO
interface sync_fifo_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic [DATA_W-1:0] data_in;
    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] data_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   fifo_cnt;
    logic              overflow;
    logic              underflow;

    modport master (
        output data_in, wr, rd,
        input  data_out, full, empty, almost_full, almost_empty, fifo_cnt, overflow, underflow
    );

    modport slave (
        input  data_in, wr, rd,
        output data_out, full, empty, almost_full, almost_empty, fifo_cnt, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with thresholds, error pulses and optional FWFT read
module sync_fifo_param #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int AFULL_TH  = 1020,
    parameter int AEMPTY_TH = 4,
    parameter int FWFT      = 0
) (
    input logic            clk,
    input logic            rst,
    sync_fifo_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_TH     = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AE_TH     = (ADDR_W+1)'(AEMPTY_TH);

    generate
        if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
            $error("sync_fifo_param: AFULL_TH must lie in 1..DEPTH");
        end
        if (AEMPTY_TH < 0 || AEMPTY_TH >= DEPTH) begin : g_bad_aempty
            $error("sync_fifo_param: AEMPTY_TH must lie in 0..DEPTH-1");
        end
        if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
            $error("sync_fifo_param: FWFT must be 0 or 1");
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic              overflow_q;
    logic              underflow_q;
    logic              wr_ok;
    logic              rd_ok;

    // Flags decode the registered count, so they settle the cycle after the causing edge.
    assign bus.full         = (cnt == CNT_DEPTH);
    assign bus.empty        = (cnt == '0);
    assign bus.almost_full  = (cnt >= AF_TH);
    assign bus.almost_empty = (cnt <= AE_TH);
    assign bus.fifo_cnt     = cnt;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    // A read frees the slot a simultaneous write needs, so full only blocks a lone write.
    assign wr_ok = bus.wr && (!bus.full || bus.rd);
    assign rd_ok = bus.rd && !bus.empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= bus.wr && bus.full && !bus.rd;
            underflow_q <= bus.rd && bus.empty;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                cnt <= cnt + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Storage is never cleared; reset only suppresses the write landing in that cycle.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    generate
        if (FWFT == 1) begin : g_fwft
            assign bus.data_out = mem[rd_ptr];
        end else begin : g_std
            logic [DATA_W-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (rd_ok) begin
                    dout_q <= mem[rd_ptr];
                end
            end
            assign bus.data_out = dout_q;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed bench for standard and FWFT FIFOs against a queue model
module tb_sync_fifo_param;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int DEPTH = 4;
    localparam int AF = 3;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus_std ();
    sync_fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus_fw ();

    assign bus_std.wr = wr;
    assign bus_std.rd = rd;
    assign bus_std.data_in = din;
    assign bus_fw.wr = wr;
    assign bus_fw.rd = rd;
    assign bus_fw.data_in = din;

    sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0)) dut_std (
        .clk (clk),
        .rst (rst),
        .bus (bus_std)
    );

    sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1)) dut_fw (
        .clk (clk),
        .rst (rst),
        .bus (bus_fw)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a plain queue of accepted words; both DUTs see identical traffic.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;
    bit            seen_rst = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_dout = '0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
            seen_rst = 1'b1;
        end else begin
            automatic bit was_full  = (q.size() == DEPTH);
            automatic bit was_empty = (q.size() == 0);
            m_ovf = wr && was_full && !rd;
            m_udf = rd && was_empty;
            if (rd && !was_empty) m_dout = q.pop_front();
            if (wr && (!was_full || rd)) q.push_back(din);
        end
    end

    always @(negedge clk) begin
        if (seen_rst) begin
            automatic int n = q.size();
            check("std.fifo_cnt", 32'(bus_std.fifo_cnt), n);
            check("std.full", 32'(bus_std.full), 32'(n == DEPTH));
            check("std.empty", 32'(bus_std.empty), 32'(n == 0));
            check("std.almost_full", 32'(bus_std.almost_full), 32'(n >= AF));
            check("std.almost_empty", 32'(bus_std.almost_empty), 32'(n <= AE));
            check("std.overflow", 32'(bus_std.overflow), 32'(m_ovf));
            check("std.underflow", 32'(bus_std.underflow), 32'(m_udf));
            check("std.data_out", 32'(bus_std.data_out), 32'(m_dout));
            check("fw.fifo_cnt", 32'(bus_fw.fifo_cnt), n);
            check("fw.overflow", 32'(bus_fw.overflow), 32'(m_ovf));
            check("fw.underflow", 32'(bus_fw.underflow), 32'(m_udf));
            if (n != 0) check("fw.data_out", 32'(bus_fw.data_out), 32'(q[0]));
        end
    end

    // Apply one cycle of stimulus, then return at the following negedge with outputs settled.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        wr = w;
        rd = r;
        din = d;
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        wr = 1'b0;
        rd = 1'b0;
        din = '0;
        @(negedge clk);
        rst = 1'b0;
        check("t1.empty", 32'(bus_std.empty), 1);
        check("t1.almost_empty", 32'(bus_std.almost_empty), 1);
        check("t1.full", 32'(bus_std.full), 0);
        check("t1.fifo_cnt", 32'(bus_std.fifo_cnt), 0);
        check("t1.data_out", 32'(bus_std.data_out), 32'h00);
        check("t1.overflow", 32'(bus_std.overflow), 0);
        check("t1.underflow", 32'(bus_std.underflow), 0);

        step(1, 0, 8'h11); check("t2.cnt1", 32'(bus_std.fifo_cnt), 1);
        step(1, 0, 8'h22); check("t2.cnt2", 32'(bus_std.fifo_cnt), 2);
        check("t2.af_at2", 32'(bus_std.almost_full), 0);
        step(1, 0, 8'h33); check("t2.cnt3", 32'(bus_std.fifo_cnt), 3);
        check("t2.af_at3", 32'(bus_std.almost_full), 1);
        step(1, 0, 8'h44); check("t2.cnt4", 32'(bus_std.fifo_cnt), 4);
        check("t2.full", 32'(bus_std.full), 1);
        step(1, 0, 8'h55); check("t2.overflow", 32'(bus_std.overflow), 1);
        check("t2.cnt_hold", 32'(bus_std.fifo_cnt), 4);
        step(0, 1, 8'h00); check("t2.rd1", 32'(bus_std.data_out), 32'h11);
        check("t2.ovf_clear", 32'(bus_std.overflow), 0);
        step(0, 1, 8'h00); check("t2.rd2", 32'(bus_std.data_out), 32'h22);
        step(0, 1, 8'h00); check("t2.rd3", 32'(bus_std.data_out), 32'h33);
        step(0, 1, 8'h00); check("t2.rd4", 32'(bus_std.data_out), 32'h44);
        check("t2.empty", 32'(bus_std.empty), 1);

        // Singles and bursts of three so both pointers wrap the 4-entry ring several times.
        step(1, 0, 8'h00); step(0, 1, 8'h00);
        check("t3.rd0", 32'(bus_std.data_out), 32'h00);
        step(1, 0, 8'h01); step(1, 0, 8'h02); step(1, 0, 8'h03);
        check("t3.cnt3", 32'(bus_std.fifo_cnt), 3);
        step(0, 1, 8'h00); step(0, 1, 8'h00); step(0, 1, 8'h00);
        check("t3.rd3", 32'(bus_std.data_out), 32'h03);
        step(1, 0, 8'h04); step(0, 1, 8'h00);
        step(1, 0, 8'h05); step(1, 0, 8'h06); step(1, 0, 8'h07);
        step(0, 1, 8'h00); step(0, 1, 8'h00); step(0, 1, 8'h00);
        check("t3.rd7", 32'(bus_std.data_out), 32'h07);
        step(1, 0, 8'h08); step(0, 1, 8'h00);
        step(1, 0, 8'h09); step(0, 1, 8'h00);
        check("t3.rd9", 32'(bus_std.data_out), 32'h09);
        check("t3.empty", 32'(bus_std.empty), 1);

        step(1, 0, 8'hB0); step(1, 0, 8'hB1); step(1, 0, 8'hB2); step(1, 0, 8'hB3);
        step(1, 1, 8'hA5);
        check("t4.full_cnt", 32'(bus_std.fifo_cnt), 4);
        check("t4.no_ovf", 32'(bus_std.overflow), 0);
        check("t4.rdB0", 32'(bus_std.data_out), 32'hB0);
        step(0, 1, 8'h00); step(0, 1, 8'h00); step(0, 1, 8'h00);
        step(0, 1, 8'h00); check("t4.rd5_A5", 32'(bus_std.data_out), 32'hA5);
        step(1, 1, 8'h5A);
        check("t4.udf", 32'(bus_std.underflow), 1);
        check("t4.cnt1", 32'(bus_std.fifo_cnt), 1);
        step(0, 1, 8'h00); check("t4.rd5A", 32'(bus_std.data_out), 32'h5A);

        step(1, 0, 8'hC1); step(1, 0, 8'hC2); step(1, 0, 8'hC3);
        check("t5.cnt3", 32'(bus_std.fifo_cnt), 3);
        rst = 1'b1;
        step(1, 0, 8'hC4);
        rst = 1'b0;
        check("t5.cnt0", 32'(bus_std.fifo_cnt), 0);
        check("t5.empty", 32'(bus_std.empty), 1);
        step(0, 1, 8'h00);
        check("t5.udf", 32'(bus_std.underflow), 1);
        check("t5.dout", 32'(bus_std.data_out), 32'h00);

        step(1, 0, 8'h77); check("t6.fw77", 32'(bus_fw.data_out), 32'h77);
        step(1, 1, 8'h88); check("t6.fw88", 32'(bus_fw.data_out), 32'h88);
        step(0, 1, 8'h00); check("t6.empty", 32'(bus_fw.empty), 1);
        step(0, 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
